inv_byte_sub_iter: RTL
======================

# inv_byte_sub_iter

Iterative AES-128 InvSubBytes engine for the decryption datapath: the inverse of the combinational `Byte_sub` stage. It accepts one 128-bit state on a start strobe and substitutes it through a single shared inverse S-box, one byte per clock, MSB byte first. The full 128-bit result is presented after 16 cycles with a one-cycle done pulse. It sits between InvShiftRows and AddRoundKey in the round-iterative decryptor, where area matters more than throughput.

## Interface
Parameters: none. The byte count (16) and byte width (8) are fixed by AES-128.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, asynchronous, active-low
- start  input  1  request; sampled only while busy=0
- data_in  input  128  state to invert; byte 0 = bits [127:120]; sampled with start
- busy  output  1  high while a substitution is in progress
- done  output  1  one-cycle pulse; isb valid and updated in this cycle
- isb  output  128  InvSubBytes result; byte i = InvSbox(data_in byte i)

## Operation
- Contains one 256-entry inverse S-box, implemented as a combinational case ROM (FIPS-197 Figure 14), plus these registers:
  - 128-bit input shift/latch `work`
  - 128-bit accumulator `acc`
  - 4-bit byte counter `cnt`
  - state register
- FSM states:
  - IDLE
    - start=1 → RUN: latch data_in into work, cnt=0, busy=1.
    - start=0 → stay in IDLE.
  - RUN, each cycle:
    - Look up work[127:120] in the inverse S-box.
    - Shift the result into acc from the LSB side (acc <= {acc[119:0], InvSbox}).
    - Shift work left by 8. Increment cnt.
    - When cnt=15, the update is the last one: isb <= {acc[119:0], InvSbox(work[127:120])}; done <= 1; busy <= 0; → IDLE.
- isb changes only at completion. It holds the previous result throughout RUN and indefinitely in IDLE.
- start while busy=1 is ignored; no queueing. data_in changes during RUN have no effect.
- start in the cycle where done=1 is legal and accepted, because busy is already 0. Back-to-back operations therefore run every 17 cycles.
- cnt wraps 15→0 on completion. No other wrap exists.
- Reset (rst_n=0, at any time):
  - Outputs: busy=0, done=0, isb=128'h0.
  - Internal: state=IDLE, cnt=0, work=0, acc=0.
  - A reset mid-operation aborts it with no done pulse, and isb returns to 0.
  - Deassertion is used as-is. The reset synchronizer lives at top level.

## Timing
- Define edge E as the edge where start=1 and busy=0 are sampled.
  - After E: busy=1.
  - Bytes 0..15 are substituted on edges E+1..E+16.
  - After E+16: done=1, busy=0, isb valid.
  - After E+17: done=0, unless a new operation completes then (impossible; minimum spacing is 17).
- Latency is 16 cycles from start acceptance to done. Throughput is one block per 17 cycles.
- busy and done are never high together.
- done is exactly one cycle wide.
- All outputs are registered. The only combinational path is work[127:120] → S-box ROM → acc/isb D inputs, one ROM deep.

## Test plan
- Reset mid-run:
  - Stimulus: start with any data, then pull rst_n low at E+5 and release it.
  - Response: busy=0, done=0 and isb=0 immediately (asynchronous). No done pulse follows.
- FIPS-197 vector:
  - Stimulus: data_in=128'hd4_27_11_ae_e0_bf_98_f1_b8_b4_5d_e5_1e_41_52_30 with start.
  - Response: done exactly at E+16; isb=128'h19_3d_e3_be_a0_f4_e2_2b_9a_c6_8d_2a_e9_f8_48_08.
- Constant inputs:
  - data_in=0 → isb=128'h5252…52 (all bytes 0x52).
  - data_in=128'h6363…63 → isb=0.
- Ignored start during run:
  - Stimulus: start at E+3 with data_in=all 0xFF.
  - Response: the first result is unaffected, and only one done pulse occurs.
  - Then start in the done cycle with data_in=all 0x16 → second done at E+33 with isb=all 0xFF.
- Byte-order check:
  - Stimulus: data_in=128'h00_01_02_…_0f.
  - Response: isb=128'h52_09_6a_d5_30_36_a5_38_bf_40_a3_9e_81_f3_d7_fb.
- Hold check: isb stays stable from completion until the next done, including throughout RUN.

Source files
------------

// File: rtl/inv_byte_sub_iter.sv
// Iterative AES-128 InvSubBytes: one shared inverse S-box, one byte per clock,
// MSB byte first; 128-bit result published with a one-cycle done pulse.
module inv_byte_sub_iter (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] data_in,
  output logic         busy,
  output logic         done,
  output logic [127:0] isb
);
  typedef enum logic {IDLE, RUN} state_t;

  state_t       state, state_next;
  logic [127:0] work, work_next;
  logic [127:0] acc, acc_next;
  logic [127:0] isb_next;
  logic [3:0]   cnt, cnt_next;
  logic         done_next;

  logic [127:0] sb_row;
  logic [6:0]   sb_sel;
  logic [7:0]   sb_out;

  // Inverse S-box ROM: high nibble picks a row, low nibble picks the byte (leftmost = column 0).
  always_comb begin
    case (work[127:124])
      4'h0:    sb_row = 128'h52096ad53036a538bf40a39e81f3d7fb;
      4'h1:    sb_row = 128'h7ce339829b2fff87348e4344c4dee9cb;
      4'h2:    sb_row = 128'h547b9432a6c2233dee4c950b42fac34e;
      4'h3:    sb_row = 128'h082ea16628d924b2765ba2496d8bd125;
      4'h4:    sb_row = 128'h72f8f66486689816d4a45ccc5d65b692;
      4'h5:    sb_row = 128'h6c704850fdedb9da5e154657a78d9d84;
      4'h6:    sb_row = 128'h90d8ab008cbcd30af7e45805b8b34506;
      4'h7:    sb_row = 128'hd02c1e8fca3f0f02c1afbd0301138a6b;
      4'h8:    sb_row = 128'h3a9111414f67dcea97f2cfcef0b4e673;
      4'h9:    sb_row = 128'h96ac7422e7ad3585e2f937e81c75df6e;
      4'ha:    sb_row = 128'h47f11a711d29c5896fb7620eaa18be1b;
      4'hb:    sb_row = 128'hfc563e4bc6d279209adbc0fe78cd5af4;
      4'hc:    sb_row = 128'h1fdda8338807c731b11210592780ec5f;
      4'hd:    sb_row = 128'h60517fa919b54a0d2de57a9f93c99cef;
      4'he:    sb_row = 128'ha0e03b4dae2af5b0c8ebbb3c83539961;
      default: sb_row = 128'h172b047eba77d626e169146355210c7d;
    endcase
    sb_sel = {~work[123:120], 3'b000};
    sb_out = sb_row[sb_sel +: 8];
  end

  assign busy = (state == RUN);

  always_comb begin
    state_next = state;
    work_next  = work;
    acc_next   = acc;
    cnt_next   = cnt;
    isb_next   = isb;
    done_next  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = RUN;
          work_next  = data_in;
          cnt_next   = 4'd0;
        end
      end
      RUN: begin
        acc_next  = {acc[119:0], sb_out};
        work_next = {work[119:0], 8'h00};
        cnt_next  = cnt + 4'd1;
        // The 16th byte goes straight into isb so the result is ready with done.
        if (cnt == 4'd15) begin
          isb_next   = {acc[119:0], sb_out};
          done_next  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      work  <= '0;
      acc   <= '0;
      cnt   <= 4'd0;
      isb   <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      work  <= work_next;
      acc   <= acc_next;
      cnt   <= cnt_next;
      isb   <= isb_next;
      done  <= done_next;
    end
  end
endmodule
